// File: rtl/crc_stream_arbiter_if.sv
// Bundle of per-source stream inputs, engine-side signals and tagged CRC
// results shared between the arbiter and its environment.
interface crc_stream_arbiter_if #(
  parameter int NUM_SRC   = 4,
  parameter int DWIDTH    = 512,
  parameter int CRC_WIDTH = 32
);
  localparam int SW = $clog2(NUM_SRC);

  logic [NUM_SRC*DWIDTH-1:0]   s_din;
  logic [NUM_SRC*DWIDTH/8-1:0] s_byteEn;
  logic [NUM_SRC-1:0]          s_dlast;
  logic [NUM_SRC-1:0]          s_vld;
  logic [NUM_SRC-1:0]          s_rdy;

  logic [DWIDTH-1:0]           eng_din;
  logic [DWIDTH/8-1:0]         eng_byteEn;
  logic                        eng_dlast;
  logic                        eng_flitEn;
  logic [CRC_WIDTH-1:0]        eng_crc;
  logic                        eng_crc_vld;

  logic [CRC_WIDTH-1:0]        crc_out;
  logic [SW-1:0]               crc_src;
  logic                        crc_out_vld;
  logic                        tag_err;

  // Arbiter side
  modport slave (
    input  s_din, s_byteEn, s_dlast, s_vld, eng_crc, eng_crc_vld,
    output s_rdy, eng_din, eng_byteEn, eng_dlast, eng_flitEn,
           crc_out, crc_src, crc_out_vld, tag_err
  );

  // Environment side: stream sources, engine and result consumer
  modport master (
    output s_din, s_byteEn, s_dlast, s_vld, eng_crc, eng_crc_vld,
    input  s_rdy, eng_din, eng_byteEn, eng_dlast, eng_flitEn,
           crc_out, crc_src, crc_out_vld, tag_err
  );
endinterface

// File: rtl/crc_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one CRC engine among NUM_SRC
// streams. Each granted packet's source index is queued in an in-order tag
// FIFO so every returned CRC can be labelled with its originating stream.
module crc_stream_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DWIDTH    = 512,
  parameter int CRC_WIDTH = 32,
  parameter int TAG_DEPTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  crc_stream_arbiter_if.slave bus
);
  localparam int SW = $clog2(NUM_SRC);
  localparam int BW = DWIDTH / 8;
  localparam int AW = $clog2(TAG_DEPTH);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t              state_q;
  logic [SW-1:0]       grant_q;
  logic [SW-1:0]       rr_ptr_q;
  logic [DWIDTH-1:0]   eng_din_q;
  logic [BW-1:0]       eng_be_q;
  logic                eng_dlast_q;
  logic                eng_flitEn_q;

  logic [AW:0]         wr_ptr_q;
  logic [AW:0]         rd_ptr_q;
  logic [SW-1:0]       tag_mem_q [TAG_DEPTH];

  logic [CRC_WIDTH-1:0] crc_out_q;
  logic [SW-1:0]        crc_src_q;
  logic                 crc_out_vld_q;
  logic                 tag_err_q;

  logic                req_any;
  logic [SW-1:0]       arb_idx_d;
  logic                fifo_full;
  logic                fifo_empty;
  logic [SW-1:0]       fifo_head;
  logic                push;
  logic                pop;
  logic                accept;
  logic [DWIDTH-1:0]   sel_din;
  logic [BW-1:0]       sel_be;
  logic                sel_dlast;

  // Round-robin search: first requester above rr_ptr, otherwise wrap to the lowest one.
  always_comb begin
    req_any   = 1'b0;
    arb_idx_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!req_any && bus.s_vld[i] && (SW'(i) > rr_ptr_q)) begin
        req_any   = 1'b1;
        arb_idx_d = SW'(i);
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!req_any && bus.s_vld[i] && (SW'(i) <= rr_ptr_q)) begin
        req_any   = 1'b1;
        arb_idx_d = SW'(i);
      end
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_head  = tag_mem_q[rd_ptr_q[AW-1:0]];

  // A full tag FIFO only holds off new grants; a packet in progress keeps flowing.
  assign push = (state_q == IDLE) && req_any && !fifo_full;
  assign pop  = bus.eng_crc_vld && !fifo_empty;

  assign accept    = (state_q == BUSY) && bus.s_vld[grant_q];
  assign sel_din   = bus.s_din[int'(grant_q)*DWIDTH +: DWIDTH];
  assign sel_be    = bus.s_byteEn[int'(grant_q)*BW +: BW];
  assign sel_dlast = bus.s_dlast[grant_q];

  assign bus.s_rdy = (state_q == BUSY) ? (NUM_SRC'(1) << grant_q) : '0;

  // Grant FSM and the registered engine-input stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= SW'(NUM_SRC - 1);
      eng_din_q    <= '0;
      eng_be_q     <= '0;
      eng_dlast_q  <= 1'b0;
      eng_flitEn_q <= 1'b0;
    end else begin
      eng_flitEn_q <= accept;
      eng_dlast_q  <= accept && sel_dlast;
      if (accept) begin
        eng_din_q <= sel_din;
        eng_be_q  <= sel_be;
      end
      case (state_q)
        IDLE: begin
          if (push) begin
            grant_q  <= arb_idx_d;
            rr_ptr_q <= arb_idx_d;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          // Returning to IDLE after dlast gives the one-cycle arbitration bubble.
          if (accept && sel_dlast) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag FIFO pointers; simultaneous push and pop leave occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Tag FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem_q[wr_ptr_q[AW-1:0]] <= arb_idx_d;
    end
  end

  // Result stage: label engine CRC with the oldest outstanding tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_out_q     <= '0;
      crc_src_q     <= '0;
      crc_out_vld_q <= 1'b0;
      tag_err_q     <= 1'b0;
    end else begin
      crc_out_q     <= bus.eng_crc;
      crc_src_q     <= fifo_empty ? '0 : fifo_head;
      crc_out_vld_q <= bus.eng_crc_vld;
      if (bus.eng_crc_vld && fifo_empty) begin
        tag_err_q <= 1'b1;
      end
    end
  end

  assign bus.eng_din     = eng_din_q;
  assign bus.eng_byteEn  = eng_be_q;
  assign bus.eng_dlast   = eng_dlast_q;
  assign bus.eng_flitEn  = eng_flitEn_q;
  assign bus.crc_out     = crc_out_q;
  assign bus.crc_src     = crc_src_q;
  assign bus.crc_out_vld = crc_out_vld_q;
  assign bus.tag_err     = tag_err_q;
endmodule

// File: doc/crc_stream_arbiter.md
Name: crc_stream_arbiter

Overview:
- Shares one crc_gen_byteEn engine among NUM_SRC independent packet streams.
- Round-robin arbitration at packet granularity: a granted source keeps the engine until its dlast flit has been forwarded.
- Registers the selected stream into the engine's din/byteEn/dlast/flitEn inputs.
- Tags each returned CRC with its source index through an in-order tag FIFO, so downstream logic knows which stream a crc_out belongs to.

Parameters:
- NUM_SRC, 4, number of requesting streams (2..16).
- DWIDTH, 512, flit data width in bits; multiple of 8.
- CRC_WIDTH, 32, width of engine CRC result.
- TAG_DEPTH, 16, depth of source-tag FIFO (power of 2) = max packets in flight inside engine.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- s_din  in  NUM_SRC*DWIDTH  per-source flit data; source i at [(i+1)*DWIDTH-1 -: DWIDTH].
- s_byteEn  in  NUM_SRC*DWIDTH/8  per-source byte enables; MSB = first byte, same packing as s_din.
- s_dlast  in  NUM_SRC  per-source last-flit flag.
- s_vld  in  NUM_SRC  per-source flit valid.
- s_rdy  out  NUM_SRC  per-source accept; flit accepted when s_vld[i]&s_rdy[i].
- eng_din  out  DWIDTH  to engine din.
- eng_byteEn  out  DWIDTH/8  to engine byteEn.
- eng_dlast  out  1  to engine dlast.
- eng_flitEn  out  1  to engine flitEn.
- eng_crc  in  CRC_WIDTH  engine crc_out.
- eng_crc_vld  in  1  engine crc_out_vld.
- crc_out  out  CRC_WIDTH  tagged CRC result.
- crc_src  out  $clog2(NUM_SRC)  source index of crc_out.
- crc_out_vld  out  1  crc_out/crc_src valid strobe.
- tag_err  out  1  sticky: eng_crc_vld arrived with tag FIFO empty.

Behaviour:
- Reset (rst=1 at posedge):
  - Clears all outputs to 0, including s_rdy, eng_*, crc_*, crc_out_vld and tag_err.
  - FSM to IDLE, tag FIFO emptied.
  - rr_ptr = NUM_SRC-1, so source 0 has first priority.
  - Reset mid-packet drops the packet silently; engine sees no further flitEn, and the engine is reset by the same rst.
- FSM IDLE:
  - If any s_vld[i] and tag FIFO not full: grant the first i with s_vld set, searching from rr_ptr+1 upward with wrap.
  - Register grant, set rr_ptr = grant, push grant index into tag FIFO, go to BUSY.
  - s_rdy all 0 in IDLE.
- FSM BUSY:
  - s_rdy[grant]=1; all other bits 0. s_rdy is combinational from the state/grant registers.
  - On an accepted flit, the next cycle carries eng_din/eng_byteEn/eng_dlast = the source's values and eng_flitEn=1.
  - Cycles with no acceptance give eng_flitEn=0; eng_dlast=0, eng_din/eng_byteEn hold.
  - Accepted flit with s_dlast=1: return to IDLE. This costs a mandatory 1-cycle arbitration bubble per packet.
- Latency: source to engine is 1 cycle; eng_crc_vld to crc_out_vld is 1 cycle.
- Flit contents are not checked. byteEn=0 or sparse byteEn is forwarded unchanged; single-flit packets (dlast on first flit) are legal.
- Tag FIFO:
  - Push at grant; pop on eng_crc_vld.
  - Simultaneous push and pop leaves occupancy unchanged.
  - Full (TAG_DEPTH entries) blocks new grants only; the current packet continues.
- Result path:
  - crc_out <= eng_crc, crc_src <= FIFO head, crc_out_vld <= eng_crc_vld.
  - If eng_crc_vld with FIFO empty: crc_src <= 0, crc_out_vld still pulses, tag_err set until rst.
- Pointer arithmetic: rr_ptr and FIFO pointers wrap modulo NUM_SRC and TAG_DEPTH respectively. FIFO uses $clog2(TAG_DEPTH)+1-bit pointers for full/empty.

Test Plan:
- Single source 0, 3-flit packet, all s_vld held:
  - Grant the cycle after the first s_vld.
  - eng_flitEn high for 3 consecutive cycles; eng_dlast on the 3rd.
  - crc_src=0 with the engine result.
- Sources 1 and 3 both valid continuously with 2-flit packets, NUM_SRC=4:
  - Grant order 1,3,1,3.
  - Exactly one idle eng_flitEn cycle between packets.
  - crc_src sequence 1,3,1,3.
- Source 2 deasserts s_vld mid-packet for 2 cycles while source 0 is valid:
  - Grant stays with 2; eng_flitEn=0 for those cycles.
  - Source 0 is granted only after source 2's dlast.
- Hold eng_crc_vld off externally until 16 packets are granted, TAG_DEPTH=16:
  - 17th packet is not granted (s_rdy=0) until the first eng_crc_vld pops a tag.
- eng_crc_vld pulse injected with FIFO empty:
  - crc_out_vld=1, crc_src=0, tag_err=1 and stays 1 until rst.
- rst asserted during flit 2 of a 4-flit packet:
  - Next cycle s_rdy=0, eng_flitEn=0, FIFO empty.
  - First post-reset grant goes to source 0 when it and source 1 are both valid.
